// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg: shared LCD geometry defaults, coordinate type, rx FSM encoding and helpers
//   H_ACTIVE_DEF/V_ACTIVE_DEF : default 800x480 active area
//   coord_t                   : 11-bit pixel/line coordinate
//   rx_state_e                : capture FSM states
package lcd_timing_pkg;
    localparam int H_ACTIVE_DEF = 800;
    localparam int V_ACTIVE_DEF = 480;
    localparam int COORD_W = 11;
    typedef logic [COORD_W-1:0] coord_t;
    typedef enum logic [1:0] {WAIT_VS, FRAME_TOP, LINE, HBLANK} rx_state_e;
    function automatic coord_t sat_inc(coord_t v);
        return (v == '1) ? v : v + coord_t'(1);
    endfunction
endpackage

// File: rtl/lcd_rx_capture_if.sv
// lcd_rx_capture_if: LCD input stream plus capture results
//   master : drives rgb_lcd_24b/hsync/vsync/lcd_de, observes results
//   slave  : the capture block, consumes the stream and drives results
interface lcd_rx_capture_if;
    import lcd_timing_pkg::*;
    logic [23:0] rgb_lcd_24b;
    logic        hsync;
    logic        vsync;
    logic        lcd_de;
    coord_t      pix_x;
    coord_t      pix_y;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        frame_start;
    logic        frame_done;
    logic [31:0] frame_checksum;
    coord_t      meas_width;
    coord_t      meas_lines;
    logic [11:0] h_total;
    logic        fmt_ok;
    logic        locked;
    logic        err_sticky;
    modport master (
        output rgb_lcd_24b, hsync, vsync, lcd_de,
        input  pix_x, pix_y, pix_data, pix_valid, frame_start, frame_done, frame_checksum,
               meas_width, meas_lines, h_total, fmt_ok, locked, err_sticky
    );
    modport slave (
        input  rgb_lcd_24b, hsync, vsync, lcd_de,
        output pix_x, pix_y, pix_data, pix_valid, frame_start, frame_done, frame_checksum,
               meas_width, meas_lines, h_total, fmt_ok, locked, err_sticky
    );
endinterface

// File: rtl/lcd_rx_frame_chk.sv
// lcd_rx_frame_chk: per-frame checksum, geometry check, lock counter and sticky error
//   pix_ok_i/pix_i         : in-range pixel to accumulate this cycle
//   line_end_i/width_i     : a line closes with the given de-high width
//   lines_i/ovf_i          : line count including a closing line, line-count overflow
//   clr_i/fin_i/vs_err_i   : new frame starts, old frame is reported, de was high at vsync
//   frame_done_o..err_sticky_o : registered frame results
module lcd_rx_frame_chk
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pix_ok_i,
    input  logic [23:0] pix_i,
    input  logic        line_end_i,
    input  coord_t      width_i,
    input  coord_t      lines_i,
    input  logic        ovf_i,
    input  logic        clr_i,
    input  logic        fin_i,
    input  logic        vs_err_i,
    output logic        frame_done_o,
    output logic [31:0] frame_checksum_o,
    output coord_t      meas_width_o,
    output coord_t      meas_lines_o,
    output logic        fmt_ok_o,
    output logic        locked_o,
    output logic        err_sticky_o
);
    localparam int LW = $clog2(LOCK_FRAMES + 1);
    logic [31:0] sum_q, sum_d, pix32;
    coord_t      wid_q, wid_d;
    logic        badw_q, badw_d, ovf_q, ovf_d, ok;
    logic [LW-1:0] lock_q, lock_d;
    always_comb begin
        pix32  = pix_ok_i ? {8'd0, pix_i} : 32'd0;
        // a pixel arriving with the vsync edge already belongs to the new frame
        sum_d  = (clr_i ? 32'd0 : sum_q) + pix32;
        wid_d  = line_end_i ? width_i : wid_q;
        badw_d = badw_q || (line_end_i && width_i != coord_t'(H_ACTIVE));
        ovf_d  = ovf_q || ovf_i;
        ok     = !badw_d && !ovf_d && !vs_err_i && lines_i == coord_t'(V_ACTIVE);
        lock_d = !ok ? '0 : (lock_q == LW'(LOCK_FRAMES)) ? lock_q : lock_q + LW'(1);
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sum_q            <= '0;
            wid_q            <= '0;
            badw_q           <= 1'b0;
            ovf_q            <= 1'b0;
            lock_q           <= '0;
            frame_done_o     <= 1'b0;
            frame_checksum_o <= '0;
            meas_width_o     <= '0;
            meas_lines_o     <= '0;
            fmt_ok_o         <= 1'b0;
            err_sticky_o     <= 1'b0;
        end else begin
            sum_q        <= sum_d;
            wid_q        <= clr_i ? '0 : wid_d;
            badw_q       <= !clr_i && badw_d;
            ovf_q        <= !clr_i && ovf_d;
            frame_done_o <= fin_i;
            err_sticky_o <= err_sticky_o || ovf_i || vs_err_i;
            if (fin_i) begin
                frame_checksum_o <= sum_q;
                meas_width_o     <= wid_d;
                meas_lines_o     <= lines_i;
                fmt_ok_o         <= ok;
                lock_q           <= lock_d;
            end
        end
    end
    assign locked_o = (lock_q == LW'(LOCK_FRAMES));
endmodule

// File: rtl/lcd_rx_capture.sv
// lcd_rx_capture: samples a parallel RGB LCD stream, recovers pixel coordinates and frame statistics
//   clk_in    : pixel clock
//   sys_rst_n : synchronous active-low reset
//   bus       : stream inputs (rgb/hsync/vsync/de) and capture outputs (pixels, frame results, h_total)
module lcd_rx_capture
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter bit VS_POL      = 1'b1,
    parameter bit HS_POL      = 1'b1,
    parameter int LOCK_FRAMES = 2
) (
    input logic             clk_in,
    input logic             sys_rst_n,
    lcd_rx_capture_if.slave bus
);
    logic [23:0] rgb_q, pix_data_q;
    logic        hs_q, vs_q, de_q, hs_qq, vs_qq, de_qq;
    logic        pix_valid_q, frame_start_q;
    logic [11:0] hcnt_q, h_total_q;
    rx_state_e   state_q, state_d;
    coord_t      x_q, x_d, y_q, y_d, ex, ey, y_fin, pix_x_q, pix_y_q;
    logic        vs_act, hs_act, de_rise, line_go, emit, pv, line_end, vs_err, ovf;
    assign vs_act  = (vs_q == VS_POL) && (vs_qq != VS_POL);
    assign hs_act  = (hs_q == HS_POL) && (hs_qq != HS_POL);
    assign de_rise = de_q && !de_qq;
    always_comb begin
        // a de rise coinciding with vsync opens the first line of the new frame
        line_go  = de_rise && (vs_act || state_q == FRAME_TOP || state_q == HBLANK);
        emit     = line_go || (state_q == LINE && de_q && !vs_act);
        ex       = line_go ? '0 : x_q;
        ey       = vs_act ? '0 : y_q;
        pv       = emit && ex < coord_t'(H_ACTIVE) && ey < coord_t'(V_ACTIVE);
        // vsync inside a line terminates it; de still high there is the protocol error
        line_end = state_q == LINE && (!de_q || vs_act);
        vs_err   = vs_act && state_q == LINE && de_q;
        y_fin    = line_end ? sat_inc(y_q) : y_q;
        ovf      = line_end && y_q == '1;
        x_d      = emit ? sat_inc(ex) : x_q;
        y_d      = vs_act ? '0 : y_fin;
        state_d  = vs_act ? (line_go ? LINE : FRAME_TOP) :
                   line_go ? LINE : line_end ? HBLANK : state_q;
    end
    always_ff @(posedge clk_in) begin
        if (!sys_rst_n) begin
            {rgb_q, hs_q, vs_q, de_q, hs_qq, vs_qq, de_qq} <= '0;
            state_q       <= WAIT_VS;
            x_q           <= '0;
            y_q           <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_data_q    <= '0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            hcnt_q        <= '0;
            h_total_q     <= '0;
        end else begin
            rgb_q         <= bus.rgb_lcd_24b;
            hs_q          <= bus.hsync;
            vs_q          <= bus.vsync;
            de_q          <= bus.lcd_de;
            hs_qq         <= hs_q;
            vs_qq         <= vs_q;
            de_qq         <= de_q;
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pix_x_q       <= ex;
            pix_y_q       <= ey;
            pix_data_q    <= rgb_q;
            pix_valid_q   <= pv;
            frame_start_q <= vs_act;
            hcnt_q        <= hs_act ? 12'd1 : hcnt_q + {11'd0, hcnt_q != '1};
            if (hs_act) h_total_q <= hcnt_q;
        end
    end
    lcd_rx_frame_chk #(
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) u_chk (
        .clk_i           (clk_in),
        .rst_ni          (sys_rst_n),
        .pix_ok_i        (pv),
        .pix_i           (rgb_q),
        .line_end_i      (line_end),
        .width_i         (x_q),
        .lines_i         (y_fin),
        .ovf_i           (ovf),
        .clr_i           (vs_act),
        .fin_i           (vs_act && state_q != WAIT_VS),
        .vs_err_i        (vs_err),
        .frame_done_o    (bus.frame_done),
        .frame_checksum_o(bus.frame_checksum),
        .meas_width_o    (bus.meas_width),
        .meas_lines_o    (bus.meas_lines),
        .fmt_ok_o        (bus.fmt_ok),
        .locked_o        (bus.locked),
        .err_sticky_o    (bus.err_sticky)
    );
    assign bus.pix_x       = pix_x_q;
    assign bus.pix_y       = pix_y_q;
    assign bus.pix_data    = pix_data_q;
    assign bus.pix_valid   = pix_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.h_total     = h_total_q;
endmodule

// File: tb/tb_lcd_rx_capture.sv
// tb_lcd_rx_capture: scoreboard bench for lcd_rx_capture on a 4x3 active area
module tb_lcd_rx_capture;
    import lcd_timing_pkg::*;
    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [23:0] d;
    } pix_t;
    typedef struct packed {
        logic [31:0] cs;
        logic [10:0] w;
        logic [10:0] l;
        logic        ok;
        logic        lk;
        logic        er;
    } frm_t;
    logic clk_in = 1'b0;
    logic sys_rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   fs_seen = 0;
    int   fs_exp = 0;
    int   by = 0;
    pix_t pq[$];
    frm_t fq[$];
    pix_t pe;
    frm_t fe;
    lcd_rx_capture_if bus ();
    lcd_rx_capture #(
        .H_ACTIVE(4), .V_ACTIVE(3), .VS_POL(1'b1), .HS_POL(1'b1), .LOCK_FRAMES(2)
    ) dut (
        .clk_in   (clk_in),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );
    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: pops expectations whenever the DUT presents a pixel or a frame result
    always @(negedge clk_in) begin
        if (bus.frame_start) fs_seen++;
        if (bus.pix_valid) begin
            if (pq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pix_unexpected: got (%0d,%0d)=0x%0h want none", bus.pix_x, bus.pix_y, bus.pix_data);
            end else begin
                pe = pq.pop_front();
                chk("pix_x", 32'(bus.pix_x), 32'(pe.x));
                chk("pix_y", 32'(bus.pix_y), 32'(pe.y));
                chk("pix_data", 32'(bus.pix_data), 32'(pe.d));
            end
        end
        if (bus.frame_done) begin
            if (fq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL frame_unexpected: got frame_done=1 checksum=0x%0h want none", bus.frame_checksum);
            end else begin
                fe = fq.pop_front();
                chk("frame_checksum", bus.frame_checksum, fe.cs);
                chk("meas_width", 32'(bus.meas_width), 32'(fe.w));
                chk("meas_lines", 32'(bus.meas_lines), 32'(fe.l));
                chk("fmt_ok", 32'(bus.fmt_ok), 32'(fe.ok));
                chk("locked", 32'(bus.locked), 32'(fe.lk));
                chk("err_sticky", 32'(bus.err_sticky), 32'(fe.er));
                chk("frame_start_with_done", 32'(bus.frame_start), 32'd1);
            end
        end
    end

    task automatic cyc(input logic de, input logic vs, input logic hs, input logic [23:0] d);
        @(negedge clk_in);
        bus.lcd_de = de;
        bus.vsync = vs;
        bus.hsync = hs;
        bus.rgb_lcd_24b = d;
    endtask

    task automatic line(input int n, input int start, input bit exp);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 24'(start + i));
            if (exp && i < 4 && by < 3) pq.push_back(pix_t'{x: 11'(i), y: 11'(by), d: 24'(start + i)});
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 24'd0);
        by++;
    endtask

    task automatic frame3(input bit exp);
        line(4, 1, exp);
        line(4, 5, exp);
        line(4, 9, exp);
    endtask

    task automatic vsp(input bit has, input frm_t f);
        cyc(1'b0, 1'b1, 1'b0, 24'd0);
        fs_exp++;
        if (has) fq.push_back(f);
        cyc(1'b0, 1'b1, 1'b0, 24'd0);
        cyc(1'b0, 1'b0, 1'b0, 24'd0);
        cyc(1'b0, 1'b0, 1'b0, 24'd0);
        by = 0;
    endtask

    task automatic hs_gap(input int n);
        cyc(1'b0, 1'b0, 1'b1, 24'd0);
        for (int i = 1; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 24'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pix_valid"}, 32'(bus.pix_valid), 32'd0);
        chk({tag, "_pix_x"}, 32'(bus.pix_x), 32'd0);
        chk({tag, "_pix_y"}, 32'(bus.pix_y), 32'd0);
        chk({tag, "_pix_data"}, 32'(bus.pix_data), 32'd0);
        chk({tag, "_frame_start"}, 32'(bus.frame_start), 32'd0);
        chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
        chk({tag, "_checksum"}, bus.frame_checksum, 32'd0);
        chk({tag, "_meas_width"}, 32'(bus.meas_width), 32'd0);
        chk({tag, "_meas_lines"}, 32'(bus.meas_lines), 32'd0);
        chk({tag, "_h_total"}, 32'(bus.h_total), 32'd0);
        chk({tag, "_fmt_ok"}, 32'(bus.fmt_ok), 32'd0);
        chk({tag, "_locked"}, 32'(bus.locked), 32'd0);
        chk({tag, "_err_sticky"}, 32'(bus.err_sticky), 32'd0);
        chk({tag, "_state"}, 32'(dut.state_q), 32'(WAIT_VS));
    endtask

    localparam frm_t F_OK0  = '{cs: 32'h4E, w: 11'd4, l: 11'd3, ok: 1'b1, lk: 1'b0, er: 1'b0};
    localparam frm_t F_OK1  = '{cs: 32'h4E, w: 11'd4, l: 11'd3, ok: 1'b1, lk: 1'b1, er: 1'b0};
    localparam frm_t F_SHRT = '{cs: 32'h42, w: 11'd4, l: 11'd3, ok: 1'b0, lk: 1'b0, er: 1'b0};
    localparam frm_t F_WIDE = '{cs: 32'h56, w: 11'd6, l: 11'd3, ok: 1'b0, lk: 1'b0, er: 1'b0};
    localparam frm_t F_ERR  = '{cs: 32'h4E, w: 11'd4, l: 11'd3, ok: 1'b0, lk: 1'b0, er: 1'b1};
    localparam frm_t F_RE0  = '{cs: 32'h4E, w: 11'd4, l: 11'd3, ok: 1'b1, lk: 1'b0, er: 1'b1};
    localparam frm_t F_RE1  = '{cs: 32'h4E, w: 11'd4, l: 11'd3, ok: 1'b1, lk: 1'b1, er: 1'b1};

    initial begin
        bus.lcd_de = 1'b0;
        bus.vsync = 1'b0;
        bus.hsync = 1'b0;
        bus.rgb_lcd_24b = 24'd0;
        repeat (3) @(negedge clk_in);
        chk_zero("init");
        sys_rst_n = 1'b1;
        // stream before any vsync is ignored
        frame3(1'b0);
        vsp(1'b0, F_OK0);
        frame3(1'b1);
        vsp(1'b1, F_OK0);
        frame3(1'b1);
        vsp(1'b1, F_OK1);
        frame3(1'b1);
        vsp(1'b1, F_OK1);
        line(4, 1, 1'b1);
        line(3, 5, 1'b1);
        line(4, 8, 1'b1);
        vsp(1'b1, F_SHRT);
        line(4, 1, 1'b1);
        line(4, 11, 1'b1);
        line(6, 5, 1'b1);
        vsp(1'b1, F_WIDE);
        // de held high across the vsync edge
        line(4, 1, 1'b1);
        line(4, 5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 24'(9 + i));
            pq.push_back(pix_t'{x: 11'(i), y: 11'(by), d: 24'(9 + i)});
        end
        cyc(1'b1, 1'b1, 1'b0, 24'd13);
        fs_exp++;
        fq.push_back(F_ERR);
        cyc(1'b0, 1'b1, 1'b0, 24'd0);
        cyc(1'b0, 1'b0, 1'b0, 24'd0);
        cyc(1'b0, 1'b0, 1'b0, 24'd0);
        by = 0;
        frame3(1'b1);
        vsp(1'b1, F_RE0);
        frame3(1'b1);
        vsp(1'b1, F_RE1);
        // hsync period measurement
        chk("h_total_before", 32'(bus.h_total), 32'd0);
        hs_gap(1056);
        hs_gap(20);
        chk("h_total_1056", 32'(bus.h_total), 32'd1056);
        hs_gap(5000);
        chk("h_total_20", 32'(bus.h_total), 32'd20);
        hs_gap(8);
        chk("h_total_sat", 32'(bus.h_total), 32'd4095);
        // reset in the middle of an out-of-range fourth line
        frame3(1'b1);
        cyc(1'b1, 1'b0, 1'b0, 24'd7);
        cyc(1'b1, 1'b0, 1'b0, 24'd8);
        cyc(1'b1, 1'b0, 1'b0, 24'd9);
        sys_rst_n = 1'b0;
        @(negedge clk_in);
        chk_zero("midrst");
        sys_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 24'(10 + i));
        cyc(1'b0, 1'b0, 1'b0, 24'd0);
        by = 0;
        frame3(1'b0);
        vsp(1'b0, F_OK0);
        frame3(1'b1);
        vsp(1'b1, F_OK0);
        repeat (6) cyc(1'b0, 1'b0, 1'b0, 24'd0);
        chk("pix_queue_empty", pq.size(), 32'd0);
        chk("frame_queue_empty", fq.size(), 32'd0);
        chk("frame_start_count", fs_seen, fs_exp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
